// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard scoreboard: tag layout, select-width helper.
package fwd_pkg;
  localparam int FWD_NONE   = 0;
  // Tag rd field is sized for the widest register address space in use.
  localparam int FWD_AW_MAX = 8;

  typedef struct packed {
    logic [FWD_AW_MAX-1:0] rd;
    logic                  wr;
    logic                  load;
    logic                  valid;
  } fwd_tag_t;

  function automatic int fwd_selw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/fwd_match_prio.sv
// One source address against the tag pipeline: per-stage hit flags and youngest-wins bypass select.
module fwd_match_prio
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SELW  = fwd_selw(DEPTH)
) (
  input  logic [FWD_AW_MAX-1:0] addr,
  input  fwd_tag_t [DEPTH-1:0]  tags,
  output logic [SELW-1:0]       sel,
  output logic [DEPTH-1:0]      hit,
  output logic [DEPTH-1:0]      ld_hit
);
  always_comb begin
    hit    = '0;
    ld_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k]    = tags[k].valid & tags[k].wr & (tags[k].rd == addr) & (addr != '0);
      ld_hit[k] = hit[k] & tags[k].load;
    end
  end

  // Oldest first so the youngest matching stage overwrites.
  always_comb begin
    sel = SELW'(FWD_NONE);
    for (int k = DEPTH-1; k >= 1; k--)
      if (hit[k]) sel = SELW'(DEPTH-k);
  end
endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit: tag pipeline EX..WB, EX/ID bypass selects, load-use and multicycle stalls.
// Optional ID-stage bypass path enabled by defining FWD_ID_PATH_EN.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter  int REG_AW     = 6,
  parameter  int DEPTH      = 3,
  parameter  int NUM_EX_SRC = 2,
  parameter  int NUM_ID_SRC = 2,
  parameter  int MC_LATW    = 4,
  localparam int SELW       = fwd_selw(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adv,
  input  logic                         flush,
  input  logic                         iss_valid,
  input  logic [REG_AW-1:0]            iss_rd,
  input  logic                         iss_wr,
  input  logic                         iss_load,
  input  logic                         iss_mc,
  input  logic [MC_LATW-1:0]           iss_mc_lat,
  input  logic [NUM_EX_SRC*REG_AW-1:0] ex_src,
  input  logic [NUM_ID_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_ID_SRC-1:0]        id_use,
  input  logic                         id_need,
  output logic [NUM_EX_SRC*SELW-1:0]   ex_fwd_sel,
  output logic [NUM_ID_SRC*SELW-1:0]   id_fwd_sel,
  output logic                         stall,
  output logic                         mc_busy
);
  localparam logic [DEPTH-1:0] LU_MASK = {DEPTH{1'b1}} >> 2;

  fwd_tag_t [DEPTH-1:0] tags;
  fwd_tag_t             iss_tag;
  logic [MC_LATW-1:0]   mc_cnt;
  logic [REG_AW-1:0]    mc_rd;
  logic                 iss_ok;

  logic [NUM_EX_SRC-1:0][DEPTH-1:0] ex_hit_unused, ex_ld_unused;
  logic [NUM_ID_SRC-1:0][DEPTH-1:0] id_hit, id_ld;
  logic [NUM_ID_SRC-1:0][SELW-1:0]  id_sel;
  logic [NUM_ID_SRC-1:0]            src_stall;

  assign iss_ok  = iss_valid & ~stall & ~flush;
  assign mc_busy = |mc_cnt;
  assign stall   = (|src_stall) | (iss_valid & iss_mc & mc_busy);

  // Multicycle results come back outside the pipeline, so their tags never advertise a write.
  always_comb begin
    iss_tag = '0;
    if (iss_ok) begin
      iss_tag.rd    = FWD_AW_MAX'(iss_rd);
      iss_tag.wr    = iss_wr & ~iss_mc;
      iss_tag.load  = iss_load;
      iss_tag.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   tags <= '0;
    else if (adv) tags <= {tags[DEPTH-2:0], iss_tag};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mc_cnt <= '0;
      mc_rd  <= '0;
    end else if (adv & iss_ok & iss_mc) begin
      mc_cnt <= (iss_mc_lat == '0) ? MC_LATW'(1) : iss_mc_lat;
      mc_rd  <= iss_wr ? iss_rd : '0;
    end else if (mc_busy) begin
      mc_cnt <= mc_cnt - MC_LATW'(1);
    end

  for (genvar i = 0; i < NUM_EX_SRC; i++) begin : g_ex
    logic [FWD_AW_MAX-1:0] a;
    assign a = FWD_AW_MAX'(ex_src[i*REG_AW +: REG_AW]);
    fwd_match_prio #(.DEPTH(DEPTH), .SELW(SELW)) u_match (
      .addr(a), .tags(tags), .sel(ex_fwd_sel[i*SELW +: SELW]),
      .hit(ex_hit_unused[i]), .ld_hit(ex_ld_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_ID_SRC; i++) begin : g_id
    logic [REG_AW-1:0]     s;
    logic [FWD_AW_MAX-1:0] a;
    logic                  need_hz;
    assign s = id_src[i*REG_AW +: REG_AW];
    assign a = FWD_AW_MAX'(s);
    fwd_match_prio #(.DEPTH(DEPTH), .SELW(SELW)) u_match (
      .addr(a), .tags(tags), .sel(id_sel[i]), .hit(id_hit[i]), .ld_hit(id_ld[i])
    );
`ifdef FWD_ID_PATH_EN
    localparam logic [DEPTH-1:0] NB_MASK = {DEPTH{1'b1}} >> 1;
    // EX result not yet bypassable to ID; loads only once they reach WB.
    assign need_hz = id_hit[i][0] | (|(id_ld[i] & NB_MASK));
`else
    assign need_hz = |id_hit[i];
`endif
    assign src_stall[i] = id_use[i] & ( (|(id_ld[i] & LU_MASK))
                                      | (id_need & need_hz)
                                      | (mc_busy & (s == mc_rd) & (|mc_rd)) );
  end

`ifdef FWD_ID_PATH_EN
  assign id_fwd_sel = id_need ? id_sel : '0;
`else
  logic id_sel_unused;
  assign id_sel_unused = ^id_sel;
  assign id_fwd_sel    = '0;
`endif
endmodule
